// File: rtl/bus_debug_bridge_if.sv
// Handshake and bus signal bundle for bus_debug_bridge.
//   rx side : i_rx_data/i_rx_valid (one-cycle byte pulse)
//   tx side : o_tx_data/o_tx_valid/i_tx_ready (valid held until accepted)
//   bus side: o_bus_req/i_bus_gnt, o_addr, o_data_wr, o_wr, o_rd, i_data_rd
//   status  : o_busy
// slave  = the bridge itself; master = the host/bus environment driving it.
interface bus_debug_bridge_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_bus_req;
  logic        i_bus_gnt;
  logic [31:0] o_addr;
  logic [31:0] o_data_wr;
  logic [3:0]  o_wr;
  logic        o_rd;
  logic [31:0] i_data_rd;
  logic        o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_bus_gnt, i_data_rd,
    output o_tx_data, o_tx_valid, o_bus_req, o_addr, o_data_wr, o_wr, o_rd, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_bus_gnt, i_data_rd,
    input  o_tx_data, o_tx_valid, o_bus_req, o_addr, o_data_wr, o_wr, o_rd, o_busy
  );
endinterface

// File: rtl/bus_debug_bridge.sv
// Byte-stream debug bridge: 'W' a0..a3 d0..d3 performs a 32-bit bus write
// and answers 'K'; 'R' a0..a3 performs a bus read and answers the 4 data
// bytes LSB first; any other command byte answers '?'. Multi-byte fields are
// LSB first. An incomplete command times out back to IDLE silently.
// Ports: i_clk, i_rst (async, active high), bus (bus_debug_bridge_if.slave).
module bus_debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RD_WAIT        = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  bus_debug_bridge_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RD_LAST = 4'(RD_WAIT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WRITE, READ, RESP} state_t;

  state_t        state_q, state_d;
  logic          rd_cmd_q, rd_cmd_d;     // 1 = 'R', 0 = 'W'
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   tx_q, tx_d;             // response bytes, current one in [7:0]
  logic [1:0]    tx_cnt_q, tx_cnt_d;     // bytes remaining after the current one
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rd_cmd_q   <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_cmd_q   <= rd_cmd_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_cmd_d   = rd_cmd_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_d       = tx_q;
    tx_cnt_d   = tx_cnt_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    unique case (state_q)
      IDLE: if (bus.i_rx_valid) begin
        to_cnt_d = '0;
        if (bus.i_rx_data == 8'h57 || bus.i_rx_data == 8'h52) begin
          rd_cmd_d   = (bus.i_rx_data == 8'h52);
          byte_cnt_d = '0;
          state_d    = ADDR;
        end else begin
          tx_d     = 32'h0000_003F;
          tx_cnt_d = '0;
          state_d  = RESP;
        end
      end
      ADDR, DATA: begin
        if (bus.i_rx_valid) begin
          // Shift in from the top so the first (LSB) byte lands in [7:0].
          if (state_q == ADDR) addr_d = {bus.i_rx_data, addr_q[31:8]};
          else                 data_d = {bus.i_rx_data, data_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          to_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = (state_q == DATA || rd_cmd_q) ? REQ : DATA;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      REQ: if (bus.i_bus_gnt) begin
        wait_cnt_d = '0;
        state_d    = rd_cmd_q ? READ : WRITE;
      end
      WRITE: begin
        tx_d     = 32'h0000_004B;
        tx_cnt_d = '0;
        state_d  = RESP;
      end
      READ: begin
        if (wait_cnt_q == RD_LAST) begin
          tx_d     = bus.i_data_rd;
          tx_cnt_d = 2'd3;
          state_d  = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RESP: if (bus.i_tx_ready) begin
        if (tx_cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          tx_d     = {8'h00, tx_q[31:8]};
          tx_cnt_d = tx_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once.
  logic drive_bus;
  assign drive_bus      = (state_q == WRITE) || (state_q == READ);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_bus_req  = (state_q == REQ) || drive_bus;
  assign bus.o_wr       = (state_q == WRITE) ? 4'hF : 4'h0;
  assign bus.o_rd       = (state_q == READ);
  assign bus.o_addr     = drive_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.o_data_wr  = (state_q == WRITE) ? data_q : 32'h0;
  assign bus.o_tx_valid = (state_q == RESP);
  assign bus.o_tx_data  = (state_q == RESP) ? tx_q[7:0] : 8'h00;

endmodule

// File: doc/bus_debug_bridge.md
BUS_DEBUG_BRIDGE -- requirements
Module: bus_debug_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles allowed between bytes inside one command.
REQ-002 Parameter RD_WAIT, default 2: cycles o_rd and o_addr are held before i_data_rd is sampled; legal range 1..15.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_rx_data  in  8  received byte.
REQ-006 i_rx_valid  in  1  one-cycle pulse, i_rx_data valid.
REQ-007 o_tx_data  out  8  response byte.
REQ-008 o_tx_valid  out  1  response byte valid; held until accepted.
REQ-009 i_tx_ready  in  1  sink accepts o_tx_data when o_tx_valid && i_tx_ready.
REQ-010 o_bus_req  out  1  request for the data bus.
REQ-011 i_bus_gnt  in  1  bus granted; bridge drives the bus only while high.
REQ-012 o_addr  out  32  bus address, bits [1:0] always 0.
REQ-013 o_data_wr  out  32  bus write data.
REQ-014 o_wr  out  4  byte write strobes.
REQ-015 o_rd  out  1  bus read strobe.
REQ-016 i_data_rd  in  32  bus read data.
REQ-017 o_busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ADDR, DATA, REQ, WRITE, READ, RESP.
REQ-019 IDLE + rx byte 0x57 ('W') or 0x52 ('R'): latch command, clear byte counter, go to ADDR.
REQ-020 IDLE + any other rx byte: load 0x3F ('?') into the tx register, go to RESP.
REQ-021 ADDR: 4 bytes, LSB first, into the address register; after the 4th byte go to DATA for 'W' and to REQ for 'R'.
REQ-022 DATA: 4 bytes, LSB first, into the write-data register; after the 4th byte go to REQ.
REQ-023 REQ: o_bus_req=1; on the first cycle with i_bus_gnt=1 go to WRITE ('W') or READ ('R'); wait indefinitely for grant, no timeout.
REQ-024 o_bus_req stays 1 from entry to REQ until the WRITE/READ state exits, then drops to 0 the same edge.
REQ-025 WRITE: exactly one cycle with o_wr=4'b1111, o_addr={addr[31:2],2'b00}, o_data_wr=data; then tx register=0x4B ('K'), go to RESP.
REQ-026 READ: o_rd=1 and o_addr stable for RD_WAIT cycles; i_data_rd captured at the edge ending the last cycle; go to RESP with 4 response bytes queued.
REQ-027 RESP: o_tx_valid=1; each handshake advances to the next byte, LSB first for read data; after the last accepted byte go to IDLE.
REQ-028 o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
REQ-029 Outside WRITE: o_wr=0. Outside READ: o_rd=0. o_addr and o_data_wr are 0 whenever o_bus_req=0.
REQ-030 rx bytes arriving in REQ, WRITE, READ or RESP are discarded, with no effect on state.
REQ-031 Timeout counter: cleared on every accepted rx byte; counts in ADDR and DATA; reaching TIMEOUT_CYCLES aborts to IDLE with no response and no bus access.
REQ-032 Byte counter is 2 bits and is cleared on ADDR entry and on DATA entry.

Reset
REQ-033 i_rst=1 forces the IDLE state asynchronously, including mid-command and mid-bus-access.
REQ-034 Reset values: all outputs 0; counters, address, data and tx registers 0.
REQ-035 After i_rst deasserts, the first rx byte is treated as a new command byte.

Verification
REQ-036 Write: rx 57 10 00 00 00 EF BE AD DE, gnt tied 1 -> one cycle o_wr=F, o_addr=0x00000010, o_data_wr=0xDEADBEEF; tx 4B.
REQ-037 Read: rx 52 04 00 00 00, bus returns 0x12345678, RD_WAIT=2 -> o_rd high 2 cycles at 0x00000004; tx 78 56 34 12.
REQ-038 Grant delay and backpressure: gnt low 10 cycles after 'R' addr, i_tx_ready toggling -> o_bus_req held 10+ cycles, no o_rd before gnt; tx bytes unchanged and in order.
REQ-039 Bad command and timeout: rx 0x41 -> tx 3F; rx 57 01 then silence for TIMEOUT_CYCLES -> back to IDLE, o_wr never asserted, no tx.
REQ-040 Reset mid-read: i_rst pulsed while o_rd=1 -> o_rd, o_bus_req, o_busy 0 immediately; next rx 52 00 00 00 00 performs a normal read.
REQ-041 Discard and alignment: rx 0x55 while in RESP is ignored; address byte 0x03 -> o_addr[1:0]=0.
